// File: rtl/collision_event_scheduler_pkg.sv
// rtl/collision_event_scheduler_pkg.sv - shared types and priority resolution for the collision scheduler
package collision_pkg;

  typedef enum logic [2:0] {
    EVT_NONE   = 3'd0,
    EVT_WALL   = 3'd1,
    EVT_BAT    = 3'd2,
    EVT_BRICK  = 3'd3,
    EVT_GROUND = 3'd4
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PRESENT,
    HOLDOFF
  } state_t;

  typedef struct packed {
    logic ground;
    logic brick;
    logic bat;
    logic wall;
  } flags_t;

  // Priority order: GROUND > BRICK > BAT > WALL
  function automatic evt_type_t resolve(input flags_t f);
    if (f.ground)     return EVT_GROUND;
    else if (f.brick) return EVT_BRICK;
    else if (f.bat)   return EVT_BAT;
    else if (f.wall)  return EVT_WALL;
    else              return EVT_NONE;
  endfunction

  function automatic logic [7:0] lost_count(input flags_t f);
    logic [7:0] n;
    n = 8'(f.ground) + 8'(f.brick) + 8'(f.bat) + 8'(f.wall);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

endpackage

// File: rtl/collision_event_scheduler_if.sv
// rtl/collision_event_scheduler_if.sv - collision event valid/ack handshake bundle
interface collision_event_scheduler_if #(
  parameter int PIX_W = 11
);
  logic             evt_valid;
  logic [2:0]       evt_type;
  logic [PIX_W-1:0] evt_pixelX;
  logic [PIX_W-1:0] evt_pixelY;
  logic             evt_ack;

  modport master (output evt_valid, evt_type, evt_pixelX, evt_pixelY, input evt_ack);
  modport slave  (input evt_valid, evt_type, evt_pixelX, evt_pixelY, output evt_ack);
endinterface

// File: rtl/collision_event_scheduler_frame_down_counter.sv
// rtl/collision_event_scheduler_frame_down_counter.sv - 8-bit loadable frame down-counter, stops at zero
module frame_down_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       dec,
  output logic [7:0] count,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/collision_event_scheduler.sv
// rtl/collision_event_scheduler.sv - frame-resolved collision events with holdoff; COLLISION_STATS_EN adds dropped_cnt
module collision_event_scheduler
  import collision_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 5,
  parameter int PIX_W          = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             startOfFrame,
  input  logic             ballDrawReq,
  input  logic             batDrawReq,
  input  logic             brickDrawReq,
  input  logic             wallDrawReq,
  input  logic             ballHitGround,
  input  logic [PIX_W-1:0] pixelX,
  input  logic [PIX_W-1:0] pixelY,
  output logic             hit,
  output logic             holdoff_active,
`ifdef COLLISION_STATS_EN
  output logic [7:0]       dropped_cnt,
`endif
  collision_event_scheduler_if.master evt
);

  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_FRAMES);

  state_t           state_q, state_d;
  flags_t           flags_q, cur;
  evt_type_t        evt_type_q;
  logic [PIX_W-1:0] evt_x_q, evt_y_q;
  logic [PIX_W-1:0] bat_x_q, bat_y_q, brick_x_q, brick_y_q;
  logic             any_flag, resolve_now, exit_holdoff, frame_start_capture;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [7:0]       cnt_value, cnt;

  assign cur = '{ground: ballHitGround,
                 brick:  ballDrawReq & brickDrawReq,
                 bat:    ballDrawReq & batDrawReq,
                 wall:   ballDrawReq & wallDrawReq};

  assign any_flag     = |flags_q;
  assign resolve_now  = (state_q == COLLECT) && startOfFrame && any_flag;
  // Leave holdoff on the pulse that takes the counter to zero so that frame is collected in full
  assign exit_holdoff = (state_q == HOLDOFF) && startOfFrame && (cnt == 8'd1 || cnt_zero);
  assign frame_start_capture = ((state_q == COLLECT) && startOfFrame) || exit_holdoff;

  frame_down_counter u_holdoff_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  assign cnt_dec = ena && (state_q == HOLDOFF) && startOfFrame;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_value = 8'd0;
    if (!ena) begin
      state_d  = IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = COLLECT;
        COLLECT: if (resolve_now) state_d = PRESENT;
        PRESENT: if (evt.evt_ack) begin
          cnt_load  = 1'b1;
          cnt_value = HOLDOFF_LOAD;
          state_d   = (HOLDOFF_LOAD == 8'd0) ? COLLECT : HOLDOFF;
        end
        HOLDOFF: if (exit_holdoff) state_d = COLLECT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !ena) begin
      flags_q    <= '0;
      evt_type_q <= EVT_NONE;
      evt_x_q    <= '0;
      evt_y_q    <= '0;
      bat_x_q    <= '0;
      bat_y_q    <= '0;
      brick_x_q  <= '0;
      brick_y_q  <= '0;
    end else begin
      // An overlap coinciding with the frame pulse opens the new frame's flags
      if (frame_start_capture) begin
        flags_q <= cur;
        if (cur.bat)   begin bat_x_q   <= pixelX; bat_y_q   <= pixelY; end
        if (cur.brick) begin brick_x_q <= pixelX; brick_y_q <= pixelY; end
      end else if (state_q == COLLECT) begin
        flags_q <= flags_q | cur;
        if (cur.bat && !flags_q.bat)     begin bat_x_q   <= pixelX; bat_y_q   <= pixelY; end
        if (cur.brick && !flags_q.brick) begin brick_x_q <= pixelX; brick_y_q <= pixelY; end
      end else if (state_q == PRESENT && evt.evt_ack) begin
        flags_q <= '0;
      end

      if (resolve_now) begin
        evt_type_q <= resolve(flags_q);
        case (resolve(flags_q))
          EVT_BRICK: begin evt_x_q <= brick_x_q; evt_y_q <= brick_y_q; end
          EVT_BAT:   begin evt_x_q <= bat_x_q;   evt_y_q <= bat_y_q;   end
          default:   begin evt_x_q <= '0;        evt_y_q <= '0;        end
        endcase
      end else if (state_q == PRESENT && evt.evt_ack) begin
        evt_type_q <= EVT_NONE;
        evt_x_q    <= '0;
        evt_y_q    <= '0;
      end
    end
  end

`ifdef COLLISION_STATS_EN
  logic [8:0] drop_sum;
  assign drop_sum = {1'b0, dropped_cnt} + {1'b0, lost_count(flags_q)};

  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_cnt <= 8'd0;
    end else if (ena && resolve_now) begin
      dropped_cnt <= drop_sum[8] ? 8'd255 : drop_sum[7:0];
    end
  end
`endif

  assign evt.evt_valid  = (state_q == PRESENT);
  assign evt.evt_type   = evt_type_q;
  assign evt.evt_pixelX = evt_x_q;
  assign evt.evt_pixelY = evt_y_q;
  assign holdoff_active = (state_q == HOLDOFF);
  assign hit = !reset && ena && (state_q == PRESENT) && evt.evt_ack && (evt_type_q == EVT_BRICK);

endmodule

// File: tb/tb_collision_event_scheduler.sv
// tb/tb_collision_event_scheduler.sv - directed self-checking bench for collision_event_scheduler
module tb_collision_event_scheduler;

  logic        clk = 1'b0;
  logic        reset, ena, ena0, sof, ball, bat, brick, wall, ground;
  logic [10:0] px, py;
  logic        hit, hold, hit0, hold0;
`ifdef COLLISION_STATS_EN
  logic [7:0]  drop, drop0;
`endif
  int total = 0;
  int bad = 0;

  collision_event_scheduler_if #(.PIX_W(11)) ev ();
  collision_event_scheduler_if #(.PIX_W(11)) ev0 ();

  collision_event_scheduler #(.HOLDOFF_FRAMES(5), .PIX_W(11)) dut (
    .clk(clk), .reset(reset), .ena(ena), .startOfFrame(sof),
    .ballDrawReq(ball), .batDrawReq(bat), .brickDrawReq(brick), .wallDrawReq(wall),
    .ballHitGround(ground), .pixelX(px), .pixelY(py),
    .hit(hit), .holdoff_active(hold),
`ifdef COLLISION_STATS_EN
    .dropped_cnt(drop),
`endif
    .evt(ev.master));

  collision_event_scheduler #(.HOLDOFF_FRAMES(0), .PIX_W(11)) dut0 (
    .clk(clk), .reset(reset), .ena(ena0), .startOfFrame(sof),
    .ballDrawReq(ball), .batDrawReq(bat), .brickDrawReq(brick), .wallDrawReq(wall),
    .ballHitGround(ground), .pixelX(px), .pixelY(py),
    .hit(hit0), .holdoff_active(hold0),
`ifdef COLLISION_STATS_EN
    .dropped_cnt(drop0),
`endif
    .evt(ev0.master));

  always #5 clk = ~clk;

  typedef struct {
    logic        has_bat;
    logic        bat_twice;
    logic [10:0] bx, by;
    logic        has_brick;
    logic [10:0] kx, ky;
    logic        has_wall;
    logic        has_ground;
    logic [2:0]  etype;
    logic [10:0] ex, ey;
    int          edrop;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // kind: 1 wall, 2 bat, 3 brick, 4 ground
  task automatic ov(input int kind, input logic [10:0] x, input logic [10:0] y);
    px = x; py = y;
    ball   = (kind != 4);
    wall   = (kind == 1);
    bat    = (kind == 2);
    brick  = (kind == 3);
    ground = (kind == 4);
    tick();
    ball = 0; wall = 0; bat = 0; brick = 0; ground = 0;
  endtask

  task automatic pulse_sof();
    sof = 1;
    tick();
    sof = 0;
  endtask

  task automatic ack_main();
    ev.evt_ack = 1;
    tick();
    ev.evt_ack = 0;
  endtask

  task automatic run_holdoff();
    for (int f = 0; f < 5; f++) begin
      tick();
      pulse_sof();
    end
  endtask

  initial begin
    int exp_drop;
    exp_drop = 0;
    vecs[0] = '{0, 0, 0, 0, 1, 100, 40, 0, 0, 3, 100, 40, 0};
    vecs[1] = '{1, 1, 60, 400, 0, 0, 0, 1, 0, 2, 60, 400, 1};
    vecs[2] = '{0, 0, 0, 0, 1, 200, 10, 0, 1, 4, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    vecs[4] = '{1, 0, 5, 6, 1, 7, 8, 1, 1, 4, 0, 0, 3};
    vecs[5] = '{1, 0, 300, 200, 1, 9, 9, 0, 0, 3, 9, 9, 1};

    reset = 1; ena = 0; ena0 = 0; sof = 0;
    ball = 0; bat = 0; brick = 0; wall = 0; ground = 0;
    px = 0; py = 0; ev.evt_ack = 0; ev0.evt_ack = 0;
    tick(); tick();
    chk("reset_valid", ev.evt_valid, 0);
    chk("reset_type", ev.evt_type, 0);
    chk("reset_hold", hold, 0);
    chk("reset_hit", hit, 0);
    chk("reset_valid0", ev0.evt_valid, 0);
    reset = 0; ena = 1;
    tick();

    pulse_sof();
    chk("empty_frame_valid", ev.evt_valid, 0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].has_wall)  ov(1, 11'd5, 11'd5);
      if (vecs[i].has_bat)   ov(2, vecs[i].bx, vecs[i].by);
      if (vecs[i].bat_twice) ov(2, vecs[i].bx + 11'd1, vecs[i].by);
      if (vecs[i].has_brick) ov(3, vecs[i].kx, vecs[i].ky);
      if (vecs[i].has_ground) ov(4, 11'd0, 11'd700);
      tick();
      sof = 1;
      #1;
      chk($sformatf("v%0d_valid_pre", i), ev.evt_valid, 0);
      tick();
      sof = 0;
      chk($sformatf("v%0d_valid", i), ev.evt_valid, 1);
      chk($sformatf("v%0d_type", i), ev.evt_type, vecs[i].etype);
      chk($sformatf("v%0d_x", i), ev.evt_pixelX, vecs[i].ex);
      chk($sformatf("v%0d_y", i), ev.evt_pixelY, vecs[i].ey);
`ifdef COLLISION_STATS_EN
      exp_drop += vecs[i].edrop;
      chk($sformatf("v%0d_drop", i), drop, exp_drop);
`endif
      ev.evt_ack = 1;
      #1;
      chk($sformatf("v%0d_hit", i), hit, (vecs[i].etype == 3) ? 1 : 0);
      tick();
      ev.evt_ack = 0;
      #1;
      chk($sformatf("v%0d_hit_after", i), hit, 0);
      chk($sformatf("v%0d_valid_after", i), ev.evt_valid, 0);
      chk($sformatf("v%0d_hold", i), hold, 1);
      for (int f = 0; f < 5; f++) begin
        tick();
        pulse_sof();
        chk($sformatf("v%0d_hold_f%0d", i, f), hold, (f < 4) ? 1 : 0);
      end
    end

    // Overlaps every frame of holdoff are ignored; exit pulse overlap opens the next frame
    ov(3, 11'd120, 11'd60);
    pulse_sof();
    chk("ho_valid", ev.evt_valid, 1);
    ack_main();
    for (int f = 0; f < 5; f++) begin
      if (f < 4) begin
        ov(3, 11'd1, 11'd1);
        pulse_sof();
        chk($sformatf("ho_f%0d_valid", f), ev.evt_valid, 0);
        chk($sformatf("ho_f%0d_hold", f), hold, 1);
      end else begin
        px = 11'd77; py = 11'd3; ball = 1; brick = 1; sof = 1;
        tick();
        ball = 0; brick = 0; sof = 0;
        chk("ho_exit_hold", hold, 0);
        chk("ho_exit_valid", ev.evt_valid, 0);
      end
    end
    ov(3, 11'd50, 11'd50);
    pulse_sof();
    chk("ho_next_valid", ev.evt_valid, 1);
    chk("ho_next_x", ev.evt_pixelX, 77);
    chk("ho_next_y", ev.evt_pixelY, 3);
    ack_main();
    run_holdoff();

    // Frame pulses while presenting do not disturb the held event
    ov(3, 11'd8, 11'd9);
    pulse_sof();
    pulse_sof();
    tick(); tick(); tick();
    chk("wait_valid", ev.evt_valid, 1);
    chk("wait_type", ev.evt_type, 3);
    chk("wait_x", ev.evt_pixelX, 8);
    ack_main();
    chk("wait_hold", hold, 1);
    run_holdoff();

    // Ack outside PRESENT is ignored
    ev.evt_ack = 1;
    #1;
    chk("stray_ack_hit", hit, 0);
    tick();
    ev.evt_ack = 0;
    chk("stray_ack_hold", hold, 0);
    chk("stray_ack_valid", ev.evt_valid, 0);

    // Dropping ena discards a pending event without a hit
    ov(3, 11'd4, 11'd4);
    pulse_sof();
    chk("abort_valid_pre", ev.evt_valid, 1);
    ena = 0;
    #1;
    chk("abort_hit", hit, 0);
    tick();
    chk("abort_valid", ev.evt_valid, 0);
    chk("abort_type", ev.evt_type, 0);
    chk("abort_hold", hold, 0);
    ena = 1;
    tick();
    pulse_sof();
    chk("abort_no_replay", ev.evt_valid, 0);

    // Zero-holdoff instance: ack returns straight to collection
    ena = 0; ena0 = 1;
    tick();
    ov(3, 11'd11, 11'd22);
    pulse_sof();
    chk("h0_valid", ev0.evt_valid, 1);
    chk("h0_type", ev0.evt_type, 3);
    chk("h0_x", ev0.evt_pixelX, 11);
    ev0.evt_ack = 1;
    #1;
    chk("h0_hit", hit0, 1);
    tick();
    ev0.evt_ack = 0;
    chk("h0_valid_after", ev0.evt_valid, 0);
    chk("h0_hold", hold0, 0);
    ov(2, 11'd33, 11'd44);
    pulse_sof();
    chk("h0_next_valid", ev0.evt_valid, 1);
    chk("h0_next_type", ev0.evt_type, 2);
    chk("h0_next_x", ev0.evt_pixelX, 33);
    chk("h0_next_y", ev0.evt_pixelY, 44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
